// File: rtl/johnson_monitor.sv
// Checker for a BITS-wide Johnson counter: decodes each sampled word to a phase,
// tracks lock, counts revolutions and errors, and exposes them on a small register bus.
module johnson_monitor #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [BITS-1:0] jc_in,
    input  logic            jc_valid,
    input  logic            valid,
    input  logic [1:0]      addr,
    input  logic [3:0]      wstrb,
    input  logic [31:0]     wdata,
    output logic            ready,
    output logic [31:0]     rdata,
    output logic            irq,
    output logic            lock_state
);

    localparam int SEQ = 2 * BITS;
    localparam int PW  = $clog2(SEQ);

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_REVS   = 2'd1;
    localparam logic [1:0] ADDR_ERRCNT = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_t;

    lock_t           state;
    lock_t           state_next;
    logic [PW-1:0]   last_phase;
    logic [31:0]     revs;
    logic [15:0]     errcnt;
    logic            err_sticky;
    logic            enable;
    logic            irq_en;

    // Bus handshake: a request (valid) is accepted on a rising edge where ready is
    // low; ready is then high for exactly the next cycle with rdata captured at the
    // accept edge. A requester holding valid across ready is re-accepted every
    // second cycle. Writes take effect on the accept edge; all-zero wstrb is a read.
    logic accept;
    logic is_write;
    logic ctrl_wr;
    logic clear;

    assign accept   = valid & ~ready;
    assign is_write = |wstrb;
    assign ctrl_wr  = accept & is_write & (addr == ADDR_CTRL) & wstrb[0];
    assign clear    = ctrl_wr & wdata[2];

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:3];

    function automatic logic [BITS-1:0] ones_low(input int n);
        logic [BITS-1:0] m;
        for (int i = 0; i < BITS; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    // Phase decode: p ones from the bottom is phase p; q zeros from the bottom
    // with all upper bits set is phase BITS+q.
    logic          dec_legal;
    logic [PW-1:0] dec_phase;

    always_comb begin
        dec_legal = 1'b0;
        dec_phase = '0;
        for (int p = 0; p <= BITS; p++) begin
            if (jc_in == ones_low(p)) begin
                dec_legal = 1'b1;
                dec_phase = PW'(p);
            end
        end
        for (int q = 1; q < BITS; q++) begin
            if (jc_in == ~ones_low(q)) begin
                dec_legal = 1'b1;
                dec_phase = PW'(BITS + q);
            end
        end
    end

    logic [PW-1:0] step_phase;
    logic          last_is_top;
    logic          sample;

    assign last_is_top = (last_phase == PW'(SEQ - 1));
    assign step_phase  = last_is_top ? '0 : last_phase + 1'b1;
    // A clear in the same cycle discards the sample completely.
    assign sample      = enable & jc_valid & ~clear;

    logic rec_phase;
    logic err_hit;
    logic rev_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= UNLOCKED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rec_phase  = 1'b0;
        err_hit    = 1'b0;
        rev_hit    = 1'b0;
        if (sample) begin
            case (state)
                UNLOCKED: begin
                    if (dec_legal) begin
                        rec_phase  = 1'b1;
                        state_next = LOCKED;
                    end else begin
                        err_hit = 1'b1;
                    end
                end
                LOCKED: begin
                    if (dec_legal && (dec_phase == last_phase)) begin
                        state_next = LOCKED;
                    end else if (dec_legal && (dec_phase == step_phase)) begin
                        rec_phase = 1'b1;
                        rev_hit   = last_is_top;
                    end else begin
                        // A skipping legal word is still recorded so relock starts from it.
                        err_hit    = 1'b1;
                        rec_phase  = dec_legal;
                        state_next = UNLOCKED;
                    end
                end
                default: state_next = UNLOCKED;
            endcase
        end
        if (clear) begin
            state_next = UNLOCKED;
        end
    end

    assign lock_state = (state == LOCKED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_phase <= '0;
            revs       <= '0;
            errcnt     <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (rec_phase) begin
                last_phase <= dec_phase;
            end
            if (clear) begin
                revs       <= '0;
                errcnt     <= '0;
                err_sticky <= 1'b0;
            end else begin
                if (rev_hit) begin
                    revs <= revs + 32'd1;
                end
                if (err_hit) begin
                    err_sticky <= 1'b1;
                    if (errcnt != 16'hFFFF) begin
                        errcnt <= errcnt + 16'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable <= 1'b0;
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable <= wdata[0];
                irq_en <= wdata[1];
            end
            irq <= err_sticky & irq_en;
        end
    end

    logic [31:0] status_word;
    logic [31:0] read_word;

    always_comb begin
        status_word           = '0;
        status_word[PW-1:0]   = last_phase;
        status_word[8]        = err_sticky;
        status_word[9]        = (state == LOCKED);
    end

    always_comb begin
        read_word = '0;
        case (addr)
            ADDR_STATUS: read_word = status_word;
            ADDR_REVS:   read_word = revs;
            ADDR_ERRCNT: read_word = {16'h0000, errcnt};
            ADDR_CTRL:   read_word = {30'd0, irq_en, enable};
            default:     read_word = '0;
        endcase
    end

    // rdata holds the pre-update register view captured at the accept edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= accept;
            if (accept) begin
                rdata <= read_word;
            end
        end
    end

endmodule

// File: doc/johnson_monitor.md
# johnson_monitor

Downstream checker for the Johnson counter stage in the user project. Samples the counter's BITS-wide Johnson state and checks that each sample is a legal codeword and a legal step. Decodes the state to a phase index and counts full revolutions and errors. Results are exposed as a small Wishbone-style register file, plus one interrupt line.

## Interface
Parameters:
- BITS, 8, Johnson counter width (≥2); sequence length 2·BITS; PW = $clog2(2·BITS)

Ports:
- clk  in  1  sole clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- jc_in  in  BITS  Johnson state from counter
- jc_valid  in  1  sample strobe; jc_in examined only when high
- valid  in  1  bus request (cyc & stb)
- addr  in  2  word select (bus address bits [3:2])
- wstrb  in  4  byte write strobes; all zero = read
- wdata  in  32  write data
- ready  out  1  one-cycle bus acknowledge
- rdata  out  32  read data, valid while ready high
- irq  out  1  err_sticky & irq_en

## Operation
- Counter step convention: next = {jc[BITS-2:0], ~jc[BITS-1]}, so the sequence from 0 is 0…01, 0…011, …, 1…1, 1…10, …, 10…0, 0…0.
- Decode:
  - Phase p (0 ≤ p ≤ BITS): the low p bits are 1 and all others 0.
  - Phase BITS+q (1 ≤ q ≤ BITS-1): the low q bits are 0 and all others 1.
  - Any other word is illegal.
- Registers:
  - addr 0 STATUS (RO): [PW-1:0] last phase, [8] err_sticky, [9] locked.
  - addr 1 REVS (RO): 32-bit revolution count; wraps on overflow.
  - addr 2 ERRCNT (RO): [15:0] error count, saturates at 0xFFFF; upper bits read 0.
  - addr 3 CTRL (RW): [0] enable, [1] irq_en, [2] clear (write-1 pulse, reads 0); other bits read 0.
  - CTRL is written only when wstrb[0] is high. Writes to RO addresses are ignored.
- Lock FSM (evaluated only on a sample = enable & jc_valid):
  - UNLOCKED:
    - Legal word: record phase, go to LOCKED, no error.
    - Illegal word: ERRCNT += 1, err_sticky set, stay UNLOCKED.
  - LOCKED, legal word whose phase equals last phase (hold): no change.
  - LOCKED, legal word whose phase equals last+1 mod 2·BITS (step):
    - Record phase.
    - If the step is 2·BITS-1 → 0, REVS += 1.
  - LOCKED, anything else (illegal word, or legal word that skips): ERRCNT += 1, err_sticky set, go to UNLOCKED.
    - A skipping legal word still records its phase.
    - The next legal sample relocks.
- enable = 0:
  - Samples are ignored and all state holds.
  - Clearing enable does not change the lock state.
- Clear (CTRL write with wdata[2] = 1) zeroes REVS, ERRCNT and err_sticky, and forces UNLOCKED.
  - Clear has priority over any sample event in the same cycle.
  - That cycle's sample is discarded entirely.
- Bus protocol:
  - A request is accepted when valid is high and ready is low.
  - ready pulses high on the following cycle, for exactly one cycle. rdata is registered and held until the next acknowledge.
  - valid held high across ready produces a new acknowledge every second cycle.
  - Write effects take place on the accept edge.

## Timing
- Reset (async assert, released synchronously to clk):
  - STATUS = 0, REVS = 0, ERRCNT = 0, CTRL = 0, UNLOCKED.
  - ready = 0, rdata = 0, irq = 0.
- Sample to register update latency: 1 cycle. A sample at edge n is visible in a read accepted at edge n+1.
- irq is registered: it asserts 1 cycle after err_sticky sets, or 1 cycle after the CTRL write that sets irq_en.
- Read latency: 1 cycle (valid → ready).
- Counter updates and a bus read in the same cycle: the read returns the pre-update value.
- reset_n asserted mid-transaction: the pending ready is dropped and no acknowledge is issued after reset releases.

## Test plan
- Reset values: pulse reset_n low, then read all 4 addresses → 0x0, 0x0, 0x0, 0x0; irq = 0; ready appears 1 cycle after each valid.
- Clean run (BITS=8): CTRL = 0x3; feed 3 full sequences from 0x00 (48 steps) with jc_valid = 1 → REVS = 3, STATUS = 0x200 (locked, phase 0), ERRCNT = 0, irq = 0.
- Illegal word: while locked at 0x0F (phase 4), inject 0x50 → ERRCNT = 1, STATUS[8] = 1, locked = 0, irq = 1 on the next cycle. Then 0x1F relocks with phase 5.
- Skip and hold: while locked, feed 0x03 → 0x03 → 0x0F → no error on the hold; the skip gives ERRCNT = 1 and records phase 4. The next 0x1F relocks.
- Clear priority: write CTRL = 0x7 in the same cycle as an illegal sample → ERRCNT = 0, err_sticky = 0, irq = 0, UNLOCKED.
- Saturation and disable:
  - Force ERRCNT to 0xFFFF via repeated illegal words; one more illegal word → ERRCNT stays 0xFFFF.
  - With enable = 0, an illegal word → no change.
